// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_e    - responder FSM states (IDLE, WAIT, RESP)
//   dmem_req_t - request fields latched at the accept edge
//   misaligned - true when a byte address is not word aligned
package dmem_pkg;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int ADDR_W   = 32;
  localparam int WORD_LSB = 2;   // byte-offset bits below the word index
  localparam int WAIT_W   = 4;   // holds WAIT_CYCLES up to 15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  function automatic logic misaligned(input logic [ADDR_W-1:0] a);
    return a[WORD_LSB-1:0] != '0;
  endfunction
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: DEPTH x 32 single-port synchronous RAM, per-byte write enables.
//   clk_i   clock
//   en_i    access strobe for this edge
//   we_i    1=write (lanes selected by be_i), 0=read into rdata_o register
//   be_i    byte-lane enables
//   idx_i   word index
//   wdata_i write data
//   rdata_o registered read data; holds until the next read
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BE_W; i++)
          if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: registered, handshaked slave for the CPU data-memory port.
//   clk, pcrst (sync, active-high)
//   req/we/addr/wdata/be  request from MEM stage, held until ready
//   ready                 IDLE only
//   rvalid/rdata/err      one-cycle response; rdata/err hold afterwards
//   rd_cnt/wr_cnt/err_cnt saturating counters when DMEM_PERF_CNT_EN is
//                         defined, constant 0 otherwise
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              pcrst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  dmem_req_t         req_q, req_d, live, acc;
  logic              access, acc_err, ram_en, rd_ok_q, err_q;
  logic [DATA_W-1:0] ram_rdata;

  assign live = '{we: we, addr: addr, wdata: wdata, be: be};
  // With zero wait states the access happens at the accept edge, so it must
  // use the live inputs; otherwise the latched copy.
  assign acc  = (state_q == IDLE) ? live : req_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    req_d   = req_q;
    access  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        req_d = live;
        if (WAIT_CYCLES == 0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          wcnt_d  = WAIT_W'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - WAIT_W'(1);
        if (wcnt_q == WAIT_W'(1)) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out of range when any index bit above the RAM's address width is set.
  assign acc_err = misaligned(acc.addr) || ((acc.addr >> (AW + WORD_LSB)) != '0);
  assign ram_en  = access && !acc_err && !pcrst;

  always_ff @(posedge clk) begin
    if (pcrst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      req_q   <= req_d;
      if (access) begin
        err_q   <= acc_err;
        rd_ok_q <= !acc_err && !acc.we;
      end
    end
  end

  dmem_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (acc.we),
    .be_i    (acc.be),
    .idx_i   (acc.addr[AW+WORD_LSB-1:WORD_LSB]),
    .wdata_i (acc.wdata),
    .rdata_o (ram_rdata)
  );

  assign ready  = (state_q == IDLE);
  assign rvalid = (state_q == RESP);
  // RAM output register only reloads on reads; masking it keeps rdata at 0
  // after writes, errors and reset.
  assign rdata  = rd_ok_q ? ram_rdata : '0;
  assign err    = err_q;

`ifdef DMEM_PERF_CNT_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  // Counted at the access edge so the new value is visible with rvalid.
  always_ff @(posedge clk) begin
    if (pcrst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (access) begin
      if (acc_err) begin
        if (~&err_cnt_q) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end else if (acc.we) begin
        if (~&wr_cnt_q) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end else begin
        if (~&rd_cnt_q) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign rd_cnt  = '0;
  assign wr_cnt  = '0;
  assign err_cnt = '0;
`endif
endmodule
